mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//  Iterative multiply/divide unit for the single-cycle datapath, downstream of the register file.
//  - Consumes the two register-file read operands (rs, rt).
//  - Computes 32x32 MULT/MULTU and DIV/DIVU into private HI/LO registers.
//  - Handshakes with the controller via start/busy/done.
//  - HI/LO are later routed to the register-file write port by the mfhi/mflo path.
// PARAMETERS
//  WIDTH   32  operand and HI/LO width; only 32 is supported
//  CNT_W   5   iteration counter width, log2(WIDTH)
// PORTS
//  clk      in   1   rising-edge clock
//  rst      in   1   asynchronous, active-high reset
//  start    in   1   request; sampled only in IDLE
//  op       in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
//  rs_data  in   32  operand A (multiplicand / dividend)
//  rt_data  in   32  operand B (multiplier / divisor)
//  cancel   in   1   pipeline flush; aborts the operation in flight
//  busy     out  1   high while state != IDLE
//  done     out  1   one-cycle pulse; HI/LO hold the new result
//  hi       out  32  MULT: upper product; DIV: remainder
//  lo       out  32  MULT: lower product; DIV: quotient
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset mid-operation discards the operation.
//  States:
//  - IDLE: on start=1, latch op and operands at edge E0 and go to CALC.
//  - CALC: one iteration per edge, E1..E32. Go to FIX when counter==31.
//  - FIX: at E33, write hi/lo, set done=1, return to IDLE. done is high between E33 and E34.
//  Latency: result visible 33 edges after the accepting edge, fixed.
//  Signed ops: operate on magnitudes, then apply signs in FIX.
//  - Product negated if operand signs differ.
//  - Quotient negated if signs differ; remainder takes the dividend's sign.
//  Multiply: shift-add over a 64-bit accumulator {hi,lo}, all 64 bits kept.
//  Divide: restoring, 33-bit partial remainder, one quotient bit per cycle.
//  Boundary cases:
//  - Divide by zero, any sign: lo=32'hFFFFFFFF, hi=rs_data unmodified, same latency.
//  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps, no trap).
//  - start while busy: ignored; no queuing, operands not re-latched.
//  - start in the cycle done=1 (state already IDLE): accepted; done falls at the next edge.
//  - cancel in CALC/FIX: IDLE at next edge, hi/lo unchanged, no done pulse. cancel has priority over FIX completion.
//  - cancel with start in IDLE: start ignored.
//  - hi/lo change only at the FIX edge; stable outputs are readable at any other time.
// CONFIGURATION
//  MULDIV_EARLY_OUT_EN defined:
//  - MULT/MULTU with rs==0 or rt==0, and any divide with rt==0, skip CALC: IDLE -> FIX.
//  - done is high after E1, i.e. latency 1.
//  - Results are identical to the full path.
//  MULDIV_EARLY_OUT_EN undefined: every operation takes the fixed 33-edge latency.
// TESTING
//  1. MULT rs=FFFFFFFF, rt=00000002 -> done after E33; hi=FFFFFFFF, lo=FFFFFFFE.
//  2. MULTU rs=FFFFFFFF, rt=00000002 -> hi=00000001, lo=FFFFFFFE. DIVU 100/7 -> lo=0000000E, hi=00000002.
//  3. DIV rs=FFFFFFF9 (-7), rt=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF.
//     DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
//  4. DIVU rs=12345678, rt=0 -> lo=FFFFFFFF, hi=12345678.
//     Latency 33, or 1 with MULDIV_EARLY_OUT_EN.
//  5. start re-asserted at E5 with new operands -> ignored, original result delivered.
//     cancel at E10 -> busy=0 at E11, hi/lo keep prior values, no done.
//  6. rst asserted asynchronously mid-CALC -> busy=done=hi=lo=0 immediately.
//     Back-to-back: start during the done cycle -> second result 33 edges later.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative 32x32 MULT/MULTU/DIV/DIVU unit with private HI/LO and start/busy/done handshake.
// Optional MULDIV_EARLY_OUT_EN: zero-operand multiplies and divide-by-zero skip the iteration phase.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned      W2        = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             is_div;
  logic             special;
  logic             neg_main;
  logic             neg_rem;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  // Request decode: magnitudes, result signs and zero-operand detection
  logic             op_div, op_signed, a_neg, b_neg, rs_zero, rt_zero;
  logic             special_c, early_c;
  logic [WIDTH-1:0] a_abs, b_abs;

  always_comb begin
    op_div    = op[1];
    op_signed = ~op[0];
    a_neg     = op_signed & rs_data[WIDTH-1];
    b_neg     = op_signed & rt_data[WIDTH-1];
    a_abs     = a_neg ? -rs_data : rs_data;
    b_abs     = b_neg ? -rt_data : rt_data;
    rs_zero   = (rs_data == '0);
    rt_zero   = (rt_data == '0);
    special_c = op_div ? rt_zero : (rs_zero | rt_zero);
`ifdef MULDIV_EARLY_OUT_EN
    early_c   = special_c;
`else
    early_c   = 1'b0;
`endif
  end

  // One shift-add / restoring-divide step, plus the sign fix-up applied in FIX
  logic [WIDTH:0]   mul_sum, div_shift, div_trial;
  logic [W2-1:0]    prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd};
    prod      = {acc_hi, acc_lo};
    prod_fix  = neg_main ? -prod : prod;
    quo_fix   = neg_main ? -acc_lo : acc_lo;
    rem_fix   = neg_rem ? -acc_hi : acc_hi;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      count    <= '0;
      is_div   <= 1'b0;
      special  <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      opnd     <= '0;
      a_raw    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !cancel) begin
            is_div   <= op_div;
            special  <= special_c;
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            opnd     <= op_div ? b_abs : a_abs;
            a_raw    <= rs_data;
            acc_hi   <= '0;
            acc_lo   <= op_div ? a_abs : b_abs;
            count    <= '0;
            busy     <= 1'b1;
            state    <= early_c ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          if (cancel) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            if (is_div) begin
              // Trial subtraction is non-negative exactly when bit WIDTH is clear
              if (!div_trial[WIDTH]) begin
                acc_hi <= div_trial[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
              end else begin
                acc_hi <= div_shift[WIDTH-1:0];
                acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
              end
            end else begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end
            count <= count + CNT_W'(1);
            if (count == LAST_ITER) state <= S_FIX;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          if (!cancel) begin
            done <= 1'b1;
            if (is_div) begin
              if (special) begin
                hi <= a_raw;
                lo <= '1;
              end else begin
                hi <= rem_fix;
                lo <= quo_fix;
              end
            end else if (special) begin
              hi <= '0;
              lo <= '0;
            end else begin
              hi <= prod_fix[W2-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
